// File: rtl/rx_frame.sv
// rtl/rx_frame.sv - SPI-side receive stage: assembles MOSI bytes into command frames for the ALU.
// Optional checksum byte is enabled with `define RX_CHECKSUM_EN.
module rx_frame #(
  parameter int FRAME_BYTES = 5
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        spi_clk,
  input  logic        spi_w,
  input  logic [7:0]  mosi,
  output logic [7:0]  cmd_op,
  output logic [15:0] cmd_a,
  output logic [15:0] cmd_b,
  output logic        cmd_valid,
  input  logic        cmd_ready,
  output logic        rx_busy,
  output logic        frame_err,
  output logic        overrun,
  output logic        chk_err
);

`ifdef RX_CHECKSUM_EN
  localparam int N_BYTES = FRAME_BYTES + 1;
`else
  localparam int N_BYTES = FRAME_BYTES;
`endif
  localparam logic [2:0] LAST = 3'(N_BYTES - 1);

  typedef enum logic [1:0] {IDLE, RECV, DONE} state_t;

  state_t     state, state_nxt;
  logic [2:0] sync;
  logic [1:0] w_pipe;
  logic [2:0] byte_cnt;
  logic [7:0] shift [N_BYTES];
  logic       rise, sample, w_fall, done, chk_bad, load;

  assign rise   = sync[1] & ~sync[2];
  assign sample = rise & spi_w;
  assign w_fall = w_pipe[1] & ~w_pipe[0];

`ifdef RX_CHECKSUM_EN
  assign chk_bad = (shift[0] ^ shift[1] ^ shift[2] ^ shift[3] ^ shift[4]) != shift[5];
`else
  assign chk_bad = 1'b0;
`endif

  // sync[0..1] is the synchronizer, sync[2] holds the previous value for edge detection
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync   <= '0;
      w_pipe <= '0;
    end else begin
      sync   <= {sync[1:0], spi_clk};
      w_pipe <= {w_pipe[0], spi_w};
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (sample) state_nxt = RECV;
      RECV: begin
        if (w_fall)                           state_nxt = IDLE;
        else if (sample && byte_cnt == LAST)  state_nxt = DONE;
      end
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_comb begin
    rx_busy   = (state != IDLE);
    frame_err = (state == RECV) && w_fall;
    done      = (state == DONE);
    load      = done && !chk_bad && (!cmd_valid || cmd_ready);
    overrun   = done && !chk_bad && cmd_valid && !cmd_ready;
`ifdef RX_CHECKSUM_EN
    chk_err   = done && chk_bad;
`else
    chk_err   = 1'b0;
`endif
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      byte_cnt <= '0;
      for (int i = 0; i < N_BYTES; i++) shift[i] <= '0;
    end else if (frame_err) begin
      byte_cnt <= '0;
    end else if (sample && state != DONE) begin
      shift[byte_cnt] <= mosi;
      byte_cnt        <= (byte_cnt == LAST) ? 3'd0 : byte_cnt + 3'd1;
    end
  end

  // A new frame may load in the same cycle the held one is accepted
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cmd_op    <= '0;
      cmd_a     <= '0;
      cmd_b     <= '0;
      cmd_valid <= 1'b0;
    end else if (load) begin
      cmd_op    <= shift[0];
      cmd_a     <= {shift[2], shift[1]};
      cmd_b     <= {shift[4], shift[3]};
      cmd_valid <= 1'b1;
    end else if (cmd_valid && cmd_ready) begin
      cmd_valid <= 1'b0;
    end
  end

endmodule

// File: tb/tb_rx_frame.sv
// tb/tb_rx_frame.sv - directed self-checking bench for rx_frame (default build).
module tb_rx_frame;
  logic        clk = 0;
  logic        rst_n, spi_clk, spi_w, cmd_ready;
  logic [7:0]  mosi;
  logic [7:0]  cmd_op;
  logic [15:0] cmd_a, cmd_b;
  logic        cmd_valid, rx_busy, frame_err, overrun, chk_err;

  int checks = 0, errors = 0;
  int ferr_cnt = 0, ovr_cnt = 0, chk_cnt = 0, acc_cnt = 0, vcyc_cnt = 0;
  int ferr0, ovr0, acc0, vcyc0;
  logic [7:0]  cap_op;
  logic [15:0] cap_a, cap_b;

  rx_frame dut (
    .clk(clk), .rst_n(rst_n), .spi_clk(spi_clk), .spi_w(spi_w), .mosi(mosi),
    .cmd_op(cmd_op), .cmd_a(cmd_a), .cmd_b(cmd_b), .cmd_valid(cmd_valid),
    .cmd_ready(cmd_ready), .rx_busy(rx_busy), .frame_err(frame_err),
    .overrun(overrun), .chk_err(chk_err)
  );

  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (frame_err) ferr_cnt++;
    if (overrun) ovr_cnt++;
    if (chk_err) chk_cnt++;
    if (cmd_valid) vcyc_cnt++;
    if (cmd_valid && cmd_ready) begin
      acc_cnt++;
      cap_op = cmd_op;
      cap_a  = cmd_a;
      cap_b  = cmd_b;
    end
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic send_byte(input logic [7:0] b);
    mosi = b;
    spi_clk = 1;
    repeat (4) step();
    spi_clk = 0;
    repeat (3) step();
  endtask

  task automatic send_frame(input logic [39:0] f);
    spi_w = 1;
    step();
    for (int i = 0; i < 5; i++) send_byte(f[39-8*i -: 8]);
    spi_w = 0;
    repeat (4) step();
  endtask

  initial begin
    rst_n = 0; spi_clk = 0; spi_w = 0; mosi = 0; cmd_ready = 0;
    repeat (3) step();
    chk("reset_op", cmd_op, 0);
    chk("reset_a", cmd_a, 0);
    chk("reset_b", cmd_b, 0);
    chk("reset_valid", cmd_valid, 0);
    chk("reset_busy", rx_busy, 0);
    chk("reset_pulses", {frame_err, overrun, chk_err}, 0);
    rst_n = 1;
    repeat (2) step();

    // Basic frame with ALU always ready
    cmd_ready = 1;
    acc0 = acc_cnt; vcyc0 = vcyc_cnt;
    send_frame(40'h03_34_12_78_56);
    chk("t1_accepts", acc_cnt - acc0, 1);
    chk("t1_valid_cycles", vcyc_cnt - vcyc0, 1);
    chk("t1_op", cap_op, 8'h03);
    chk("t1_a", cap_a, 16'h1234);
    chk("t1_b", cap_b, 16'h5678);
    chk("t1_no_overrun", ovr_cnt, 0);

    // Abort after two bytes, then a clean frame
    ferr0 = ferr_cnt; acc0 = acc_cnt;
    spi_w = 1;
    step();
    send_byte(8'hEE);
    send_byte(8'hFF);
    chk("t3_busy_mid", rx_busy, 1);
    spi_w = 0;
    repeat (6) step();
    chk("t3_frame_err", ferr_cnt - ferr0, 1);
    chk("t3_busy_idle", rx_busy, 0);
    chk("t3_no_accept", acc_cnt - acc0, 0);
    send_frame(40'h01_02_00_03_00);
    chk("t3_accepts", acc_cnt - acc0, 1);
    chk("t3_op", cap_op, 8'h01);
    chk("t3_a", cap_a, 16'h0002);
    chk("t3_b", cap_b, 16'h0003);

    // Reset in the middle of a frame
    spi_w = 1;
    step();
    send_byte(8'h77);
    send_byte(8'h66);
    send_byte(8'h55);
    rst_n = 0;
    #1;
    chk("t4_busy_in_reset", rx_busy, 0);
    step();
    spi_w = 0;
    step();
    rst_n = 1;
    repeat (2) step();
    acc0 = acc_cnt;
    send_frame(40'hA5_01_02_03_04);
    chk("t4_accepts", acc_cnt - acc0, 1);
    chk("t4_op", cap_op, 8'hA5);
    chk("t4_a", cap_a, 16'h0201);
    chk("t4_b", cap_b, 16'h0403);

    // ALU stalled: A held, B dropped with overrun
    cmd_ready = 0;
    ovr0 = ovr_cnt; acc0 = acc_cnt;
    send_frame(40'h11_22_33_44_55);
    chk("t2_valid_a", cmd_valid, 1);
    chk("t2_op_a", cmd_op, 8'h11);
    send_frame(40'h99_AA_BB_CC_DD);
    chk("t2_overrun", ovr_cnt - ovr0, 1);
    chk("t2_op_held", cmd_op, 8'h11);
    chk("t2_a_held", cmd_a, 16'h3322);
    chk("t2_b_held", cmd_b, 16'h5544);
    cmd_ready = 1;
    step();
    cmd_ready = 0;
    chk("t2_valid_cleared", cmd_valid, 0);
    chk("t2_accepts", acc_cnt - acc0, 1);
    chk("t2_cap_op", cap_op, 8'h11);
    repeat (4) step();
    chk("t2_b_not_delivered", cmd_valid, 0);

    // Accept the held command in the exact DONE cycle of the next frame
    send_frame(40'h21_43_65_87_A9);
    chk("t5_held_c", cmd_valid, 1);
    ovr0 = ovr_cnt; acc0 = acc_cnt;
    spi_w = 1;
    step();
    send_byte(8'h5A);
    send_byte(8'hBC);
    send_byte(8'h9A);
    send_byte(8'hF0);
    mosi = 8'hDE;
    spi_clk = 1;
    repeat (3) step();
    chk("t5_busy_done", rx_busy, 1);
    cmd_ready = 1;
    step();
    cmd_ready = 0;
    chk("t5_accept_c", acc_cnt - acc0, 1);
    chk("t5_cap_op_c", cap_op, 8'h21);
    chk("t5_valid_d", cmd_valid, 1);
    chk("t5_op_d", cmd_op, 8'h5A);
    chk("t5_a_d", cmd_a, 16'h9ABC);
    chk("t5_b_d", cmd_b, 16'hDEF0);
    chk("t5_no_overrun", ovr_cnt - ovr0, 0);
    spi_clk = 0;
    repeat (3) step();
    spi_w = 0;
    repeat (4) step();
    cmd_ready = 1;
    step();
    cmd_ready = 0;
    chk("t5_drained", cmd_valid, 0);
    chk("chk_err_never", chk_cnt, 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
